ecc_point_sequencer: RTL and testbench

Microcoded controller that sequences the shared modular ALU core (`ECC_core`: add/sub/mult/inv mod prime) to compute one affine elliptic-curve point operation.
- Supports point addition R = P + Q and point doubling R = 2P on y^2 = x^3 + a·x + b over GF(prime).
- Holds operands and temporaries in an internal register file.
- Issues one core operation at a time over the core's start/done handshake.
- Sits between the top-level scalar-multiply loop and `ECC_core`.

---
 rtl/ecc_point_sequencer_pkg.sv | 33 +++
 rtl/ecc_point_sequencer_if.sv | 21 ++
 rtl/ecc_point_sequencer_uop_rom.sv | 43 ++++
 rtl/ecc_point_sequencer.sv | 133 +++++++++++++
 tb/tb_ecc_point_sequencer.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ecc_point_sequencer_pkg.sv
// Shared types for the affine EC point sequencer: ALU op codes, micro-op
// layout, FSM states and program lengths.
package ecc_pkg;

    typedef enum logic [2:0] {
        ADD  = 3'b001,
        SUB  = 3'b010,
        MULT = 3'b011,
        INV  = 3'b100
    } alu_sel_t;

    typedef struct packed {
        alu_sel_t   sel;
        logic [2:0] src_a;
        logic [2:0] src_b;
        logic [2:0] dst;
    } uop_t;

    typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT, GAP, DONE} state_t;

    localparam int ADD_LEN = 10;
    localparam int DBL_LEN = 13;

    function automatic uop_t mk_uop(alu_sel_t sel, logic [2:0] a, logic [2:0] b, logic [2:0] d);
        uop_t u;
        u.sel   = sel;
        u.src_a = a;
        u.src_b = b;
        u.dst   = d;
        return u;
    endfunction

endpackage

// File: rtl/ecc_point_sequencer_if.sv
// Start/done handshake and operand bus between the sequencer (master) and
// the shared modular ALU core (slave).
interface ecc_point_sequencer_if #(parameter int W = 256);
    logic         o_core_start;
    logic [W-1:0] o_core_a;
    logic [W-1:0] o_core_b;
    logic [W-1:0] o_core_prime;
    logic [2:0]   o_core_sel;
    logic [W-1:0] i_core_result;
    logic         i_core_done;

    modport master (
        output o_core_start, o_core_a, o_core_b, o_core_prime, o_core_sel,
        input  i_core_result, i_core_done
    );

    modport slave (
        input  o_core_start, o_core_a, o_core_b, o_core_prime, o_core_sel,
        output i_core_result, i_core_done
    );
endinterface

// File: rtl/ecc_point_sequencer_uop_rom.sv
// Microcode ROM: affine point-add (mode 0) and point-double (mode 1) programs
// over the register map R0=x1 R1=y1 R2=x2 R3=y2 R7=a, R4..R6 temporaries.
module ecc_uop_rom
    import ecc_pkg::*;
(
    input  logic       i_mode,
    input  logic [3:0] i_upc,
    output uop_t       o_uop
);
    logic [4:0] w_idx;
    assign w_idx = {i_mode, i_upc};

    // Add: lambda=(y2-y1)/(x2-x1) in R4; double: lambda=(3x1^2+a)/(2y1) in R4.
    always_comb begin
        o_uop = mk_uop(ADD, 3'd0, 3'd0, 3'd0);
        case (w_idx)
            5'd0:  o_uop = mk_uop(SUB,  3'd3, 3'd1, 3'd4);
            5'd1:  o_uop = mk_uop(SUB,  3'd2, 3'd0, 3'd5);
            5'd2:  o_uop = mk_uop(INV,  3'd5, 3'd5, 3'd5);
            5'd3:  o_uop = mk_uop(MULT, 3'd4, 3'd5, 3'd4);
            5'd4:  o_uop = mk_uop(MULT, 3'd4, 3'd4, 3'd5);
            5'd5:  o_uop = mk_uop(SUB,  3'd5, 3'd0, 3'd5);
            5'd6:  o_uop = mk_uop(SUB,  3'd5, 3'd2, 3'd5);
            5'd7:  o_uop = mk_uop(SUB,  3'd0, 3'd5, 3'd6);
            5'd8:  o_uop = mk_uop(MULT, 3'd4, 3'd6, 3'd6);
            5'd9:  o_uop = mk_uop(SUB,  3'd6, 3'd1, 3'd6);
            5'd16: o_uop = mk_uop(MULT, 3'd0, 3'd0, 3'd4);
            5'd17: o_uop = mk_uop(ADD,  3'd4, 3'd4, 3'd5);
            5'd18: o_uop = mk_uop(ADD,  3'd5, 3'd4, 3'd4);
            5'd19: o_uop = mk_uop(ADD,  3'd4, 3'd7, 3'd4);
            5'd20: o_uop = mk_uop(ADD,  3'd1, 3'd1, 3'd5);
            5'd21: o_uop = mk_uop(INV,  3'd5, 3'd5, 3'd5);
            5'd22: o_uop = mk_uop(MULT, 3'd4, 3'd5, 3'd4);
            5'd23: o_uop = mk_uop(MULT, 3'd4, 3'd4, 3'd5);
            5'd24: o_uop = mk_uop(SUB,  3'd5, 3'd0, 3'd5);
            5'd25: o_uop = mk_uop(SUB,  3'd5, 3'd0, 3'd5);
            5'd26: o_uop = mk_uop(SUB,  3'd0, 3'd5, 3'd6);
            5'd27: o_uop = mk_uop(MULT, 3'd4, 3'd6, 3'd6);
            5'd28: o_uop = mk_uop(SUB,  3'd6, 3'd1, 3'd6);
            default: o_uop = mk_uop(ADD, 3'd0, 3'd0, 3'd0);
        endcase
    end
endmodule

// File: rtl/ecc_point_sequencer.sv
// Affine EC point add/double controller: walks a micro-op program, issuing one
// modular ALU operation at a time and writing results back to a small register file.
module ecc_point_sequencer
    import ecc_pkg::*;
#(
    parameter int W    = 256,
    parameter int NREG = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic         i_mode,
    input  logic [W-1:0] i_x1,
    input  logic [W-1:0] i_y1,
    input  logic [W-1:0] i_x2,
    input  logic [W-1:0] i_y2,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_prime,
    output logic [W-1:0] o_x3,
    output logic [W-1:0] o_y3,
    output logic         o_inf,
    output logic         o_busy,
    output logic         o_done,
    ecc_point_sequencer_if.master core
);
    state_t       r_state, w_state_next;
    logic [W-1:0] r_rf [NREG];
    logic [W-1:0] r_prime, r_x3, r_y3;
    logic         r_mode, r_inf;
    logic [3:0]   r_upc;

    uop_t         w_uop;
    logic         w_last, w_degenerate, w_active;
    logic         w_core_start;
    logic [W-1:0] w_core_a, w_core_b, w_core_prime;
    logic [2:0]   w_core_sel;

    ecc_uop_rom u_rom (
        .i_mode (r_mode),
        .i_upc  (r_upc),
        .o_uop  (w_uop)
    );

    assign w_last       = r_mode ? (r_upc == 4'(DBL_LEN - 1)) : (r_upc == 4'(ADD_LEN - 1));
    assign w_degenerate = r_mode ? (r_rf[1] == '0) : (r_rf[0] == r_rf[2]);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // Core strobe and operands decode straight from state so they drop the
    // moment reset hits and stay low for only the GAP cycle between ops.
    always_comb begin
        w_state_next = r_state;
        w_active     = (r_state == ISSUE) || (r_state == WAIT);
        w_core_start = w_active;
        w_core_sel   = 3'b000;
        w_core_a     = '0;
        w_core_b     = '0;
        w_core_prime = '0;
        if (w_active) begin
            w_core_sel   = w_uop.sel;
            w_core_a     = r_rf[w_uop.src_a];
            w_core_b     = (w_uop.sel == INV) ? W'(1) : r_rf[w_uop.src_b];
            w_core_prime = r_prime;
        end
        case (r_state)
            IDLE:    if (i_start) w_state_next = CHECK;
            CHECK:   w_state_next = w_degenerate ? DONE : ISSUE;
            ISSUE:   w_state_next = WAIT;
            WAIT:    if (core.i_core_done) w_state_next = GAP;
            GAP:     w_state_next = w_last ? DONE : ISSUE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
            r_prime <= '0;
            r_x3    <= '0;
            r_y3    <= '0;
            r_mode  <= 1'b0;
            r_inf   <= 1'b0;
            r_upc   <= '0;
        end else begin
            case (r_state)
                IDLE: if (i_start) begin
                    r_rf[0] <= i_x1;
                    r_rf[1] <= i_y1;
                    r_rf[2] <= i_x2;
                    r_rf[3] <= i_y2;
                    r_rf[7] <= i_a;
                    r_prime <= i_prime;
                    r_mode  <= i_mode;
                    r_inf   <= 1'b0;
                end
                CHECK: begin
                    r_upc <= '0;
                    if (w_degenerate) begin
                        r_inf <= 1'b1;
                        r_x3  <= '0;
                        r_y3  <= '0;
                    end
                end
                WAIT: if (core.i_core_done) r_rf[w_uop.dst] <= core.i_core_result;
                GAP: begin
                    if (w_last) begin
                        r_x3 <= r_rf[5];
                        r_y3 <= r_rf[6];
                    end else begin
                        r_upc <= r_upc + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_x3   = r_x3;
    assign o_y3   = r_y3;
    assign o_inf  = r_inf;
    assign o_done = (r_state == DONE);
    assign o_busy = (r_state != IDLE) && (r_state != DONE);

    assign core.o_core_start = w_core_start;
    assign core.o_core_a     = w_core_a;
    assign core.o_core_b     = w_core_b;
    assign core.o_core_prime = w_core_prime;
    assign core.o_core_sel   = w_core_sel;
endmodule

// File: tb/tb_ecc_point_sequencer.sv
// Self-checking bench: behavioural modular-ALU core plus an affine-formula
// reference model for point add/double.
module tb_ecc_point_sequencer;
    import ecc_pkg::*;
    localparam int W = 256;
    typedef longint unsigned u64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         tb_start = 1'b0, tb_mode = 1'b0;
    logic [W-1:0] tb_x1 = '0, tb_y1 = '0, tb_x2 = '0, tb_y2 = '0, tb_a = '0, tb_p = '0;
    logic [W-1:0] x3, y3;
    logic         inf, busy, done;

    ecc_point_sequencer_if #(.W(W)) bus ();

    ecc_point_sequencer #(.W(W), .NREG(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(tb_start), .i_mode(tb_mode),
        .i_x1(tb_x1), .i_y1(tb_y1), .i_x2(tb_x2), .i_y2(tb_y2),
        .i_a(tb_a), .i_prime(tb_p),
        .o_x3(x3), .o_y3(y3), .o_inf(inf), .o_busy(busy), .o_done(done),
        .core(bus)
    );

    int n_tests = 0, n_fail = 0;

    function automatic u64 mpow(u64 b, u64 e, u64 p);
        u64 r = 1;
        b = b % p;
        while (e > 0) begin
            if (e[0]) r = (r * b) % p;
            b = (b * b) % p;
            e = e >> 1;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] alu(logic [2:0] sel, logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] p);
        u64 av = a[63:0], bv = b[63:0], pv = p[63:0], r;
        case (sel)
            3'b001:  r = (av + bv) % pv;
            3'b010:  r = (av + pv - bv) % pv;
            3'b011:  r = (av * bv) % pv;
            3'b100:  r = mpow(av, pv - 2, pv);
            default: r = 0;
        endcase
        return W'(r);
    endfunction

    // Reference: textbook affine formulas, lambda via Fermat inverse.
    task automatic ref_point(input bit mode, input u64 x1, y1, x2, y2, a, p,
                             output u64 rx, ry, output bit rinf);
        u64 num, den, lam;
        if (mode ? (y1 == 0) : (x1 == x2)) begin
            rinf = 1; rx = 0; ry = 0;
        end else begin
            rinf = 0;
            num = mode ? (3 * x1 * x1 + a) % p : (y2 + p - y1) % p;
            den = mode ? (2 * y1) % p : (x2 + p - x1) % p;
            lam = (num * mpow(den, p - 2, p)) % p;
            rx  = ((lam * lam) % p + 2 * p - x1 - (mode ? x1 : x2)) % p;
            ry  = ((lam * ((x1 + p - rx) % p)) % p + p - y1) % p;
        end
    endtask

    // Core stand-in: done (level) after cur_lat cycles of start, cleared once start drops.
    int   core_lat = 1;
    bit   core_var = 1'b0;
    int   cur_lat = 1;
    int   core_cnt = 0;
    logic core_done_r;
    logic [W-1:0] core_res_r;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            core_done_r <= 1'b0;
            core_cnt    <= 0;
            core_res_r  <= '0;
        end else if (!bus.o_core_start) begin
            core_done_r <= 1'b0;
            core_cnt    <= 0;
            cur_lat     <= core_var ? int'($urandom_range(1, 20)) : core_lat;
        end else if (!core_done_r) begin
            if (core_cnt + 1 >= cur_lat) begin
                core_done_r <= 1'b1;
                core_res_r  <= alu(bus.o_core_sel, bus.o_core_a, bus.o_core_b, bus.o_core_prime);
            end else begin
                core_cnt <= core_cnt + 1;
            end
        end
    end
    assign bus.i_core_done   = core_done_r;
    assign bus.i_core_result = core_res_r;

    // Bus monitor: start rising edges, operand stability, single-cycle gaps, done pulses.
    int   rise_cnt = 0, stab_err = 0, gap_err = 0, done_cnt = 0, low_len = 0;
    logic prev_start = 1'b0, gap_armed = 1'b0;
    logic [W-1:0] prev_a = '0, prev_b = '0;
    logic [2:0]   prev_sel = '0;
    always @(negedge clk) begin
        if (rst) begin
            prev_start <= 1'b0;
            gap_armed  <= 1'b0;
        end else begin
            if (bus.o_core_start && !prev_start) begin
                rise_cnt <= rise_cnt + 1;
                if (gap_armed && low_len != 1) gap_err <= gap_err + 1;
            end
            if (bus.o_core_start && prev_start &&
                (bus.o_core_a !== prev_a || bus.o_core_b !== prev_b || bus.o_core_sel !== prev_sel))
                stab_err <= stab_err + 1;
            if (!busy) gap_armed <= 1'b0;
            else if (!bus.o_core_start && prev_start) gap_armed <= 1'b1;
            else if (bus.o_core_start && !prev_start) gap_armed <= 1'b0;
            if (!bus.o_core_start && prev_start) low_len <= 1;
            else if (!bus.o_core_start) low_len <= low_len + 1;
            if (done) done_cnt <= done_cnt + 1;
            prev_start <= bus.o_core_start;
            prev_a     <= bus.o_core_a;
            prev_b     <= bus.o_core_b;
            prev_sel   <= bus.o_core_sel;
        end
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("[TB] ok %s = %0h", name, act);
        end
    endtask

    // cyc = clock edges from the start-sampling edge to the cycle showing o_done.
    task automatic run_op(input bit mode, input u64 x1, y1, x2, y2, a, p, input int intf,
                          output logic [W-1:0] rx, ry, output logic rinf,
                          output int ops, output int cyc, output bit tmo);
        int r0;
        @(negedge clk);
        tb_mode = mode; tb_x1 = W'(x1); tb_y1 = W'(y1); tb_x2 = W'(x2);
        tb_y2 = W'(y2); tb_a = W'(a); tb_p = W'(p); tb_start = 1'b1;
        @(posedge clk);
        #1 tb_start = 1'b0;
        r0  = rise_cnt;
        cyc = 1;
        tmo = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (done) begin
                tmo = 1'b0;
                break;
            end
            tb_start = (cyc == intf);
            if (cyc == intf) begin
                tb_x1   = tb_x1 ^ W'(1);
                tb_mode = ~mode;
            end
            @(posedge clk);
            cyc++;
        end
        tb_start = 1'b0;
        rx = x3; ry = y3; rinf = inf;
        ops = rise_cnt - r0;
        if (tmo) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: o_done not seen, required within 3000 cycles");
        end
    endtask

    typedef struct {
        bit mode;
        u64 x1, y1, x2, y2, a, p, ex3, ey3;
        bit einf;
        int eops;
        int ecyc;
    } vec_t;
    vec_t tbl[4];

    logic [W-1:0] rx, ry;
    logic         rinf;
    int           ops, cyc, d0, s0, g0;
    bit           tmo;
    u64           ex, ey;
    bit           einf;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // With a 1-cycle core each op costs ISSUE + WAIT + GAP = 3 cycles.
        tbl[0] = '{1'b1, 3, 6, 0, 0, 2, 97, 'h50, 'h0A, 1'b0, 13, 41};
        tbl[1] = '{1'b0, 3, 6, 'h50, 'h0A, 2, 97, 'h50, 'h57, 1'b0, 10, 32};
        tbl[2] = '{1'b0, 3, 6, 3, 'h5B, 2, 97, 0, 0, 1'b1, 0, 2};
        tbl[3] = '{1'b1, 5, 0, 0, 0, 2, 97, 0, 0, 1'b1, 0, 2};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_x3", x3, '0);
        check("reset_y3", y3, '0);
        check("reset_inf_busy_done_start", W'({inf, busy, done, bus.o_core_start}), '0);
        rst = 1'b0;

        core_var = 1'b0;
        core_lat = 1;
        for (int i = 0; i < 4; i++) begin
            d0 = done_cnt;
            run_op(tbl[i].mode, tbl[i].x1, tbl[i].y1, tbl[i].x2, tbl[i].y2, tbl[i].a, tbl[i].p,
                   -1, rx, ry, rinf, ops, cyc, tmo);
            check($sformatf("vec%0d_x3", i), rx, W'(tbl[i].ex3));
            check($sformatf("vec%0d_y3", i), ry, W'(tbl[i].ey3));
            check($sformatf("vec%0d_inf", i), W'(rinf), W'(tbl[i].einf));
            check($sformatf("vec%0d_core_starts", i), W'(ops), W'(tbl[i].eops));
            check($sformatf("vec%0d_latency", i), W'(cyc), W'(tbl[i].ecyc));
            repeat (2) @(posedge clk);
            check($sformatf("vec%0d_done_pulses", i), W'(done_cnt - d0), W'(1));
        end

        // Second start while busy must be ignored.
        d0 = done_cnt;
        run_op(1'b0, 3, 6, 'h50, 'h0A, 2, 97, 10, rx, ry, rinf, ops, cyc, tmo);
        check("busy_start_x3", rx, W'('h50));
        check("busy_start_y3", ry, W'('h57));
        check("busy_start_ops", W'(ops), W'(10));
        repeat (4) @(posedge clk);
        check("busy_start_done_pulses", W'(done_cnt - d0), W'(1));

        // Reset during WAIT of op 5 of an add.
        core_lat = 6;
        @(negedge clk);
        tb_mode = 1'b0; tb_x1 = W'(3); tb_y1 = W'(6); tb_x2 = W'('h50); tb_y2 = W'('h0A);
        tb_a = W'(2); tb_p = W'(97); tb_start = 1'b1;
        @(posedge clk);
        #1 tb_start = 1'b0;
        d0 = rise_cnt;
        for (int k = 0; k < 500 && (rise_cnt - d0) < 5; k++) begin
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        check("mid_wait_start_high", W'(bus.o_core_start), W'(1));
        rst = 1'b1;
        #1;
        check("rst_async_start_busy_done", W'({bus.o_core_start, busy, done}), '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        core_lat = 1;
        run_op(1'b1, 3, 6, 0, 0, 2, 97, -1, rx, ry, rinf, ops, cyc, tmo);
        check("post_rst_x3", rx, W'('h50));
        check("post_rst_y3", ry, W'('h0A));
        check("post_rst_ops", W'(ops), W'(13));

        // Randomized points, variable core latency, checked against the formulas.
        core_var = 1'b1;
        s0 = stab_err;
        g0 = gap_err;
        for (int i = 0; i < 24; i++) begin
            u64 primes[8] = '{97, 101, 103, 107, 109, 113, 127, 251};
            u64 p, x1, y1, x2, y2, a;
            bit mode;
            p    = primes[$urandom_range(0, 7)];
            mode = 1'($urandom_range(0, 1));
            x1   = $urandom_range(0, 32'(p - 1));
            y1   = $urandom_range(0, 32'(p - 1));
            x2   = $urandom_range(0, 32'(p - 1));
            y2   = $urandom_range(0, 32'(p - 1));
            a    = $urandom_range(0, 32'(p - 1));
            if ($urandom_range(0, 3) == 0) begin
                if (mode) y1 = 0;
                else      x2 = x1;
            end
            ref_point(mode, x1, y1, x2, y2, a, p, ex, ey, einf);
            run_op(mode, x1, y1, x2, y2, a, p, -1, rx, ry, rinf, ops, cyc, tmo);
            check($sformatf("rnd%0d_m%0d_x3", i, mode), rx, W'(ex));
            check($sformatf("rnd%0d_m%0d_y3", i, mode), ry, W'(ey));
            check($sformatf("rnd%0d_inf", i), W'(rinf), W'(einf));
            check($sformatf("rnd%0d_ops", i), W'(ops), W'(einf ? 0 : (mode ? 13 : 10)));
        end
        check("operand_stability_errors", W'(stab_err - s0), '0);
        check("start_gap_errors", W'(gap_err - g0), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
